// File: rtl/mem_pkg.sv
// mem_pkg: access size encodings, default RAM depth and FSM states shared by
// mem_access_unit and its byte aligner.
package mem_pkg;
    localparam int ADDR_DEPTH_DEF = 2048;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_WORD = 2'd1, SZ_DWORD = 2'd2, SZ_ILL = 2'd3} size_e;
    typedef enum logic [2:0] {IDLE, RD0, RD1, WR_ISSUE, WR_WAIT, RESP} state_e;
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return sz == SZ_DWORD ? 4'd8 : sz == SZ_WORD ? 4'd4 : 4'd1;
    endfunction
    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        return sz == SZ_DWORD ? 64'hFFFF_FFFF_FFFF_FFFF : sz == SZ_WORD ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
    endfunction
endpackage

// File: rtl/mem_byte_align.sv
// mem_byte_align: pick the requested bytes out of a 16-byte read window,
// right-justified and zero-extended to 64 bits.
module mem_byte_align
    import mem_pkg::*;
(
    input  logic [63:0] lo,
    input  logic [63:0] hi,
    input  logic [1:0]  shift,
    input  logic [1:0]  size,
    output logic [63:0] data
);
    logic [127:0] win;
    assign win  = {hi, lo} >> {shift, 3'b000};
    assign data = win[63:0] & size_mask(size);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: serialises byte/word/dword loads and stores of any alignment
// onto a RAM with a word-aligned 8-byte read window and a single write port.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_DEPTH = ADDR_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_type,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [63:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr_wr,
    output logic [63:0]           ram_data_wr,
    output logic [1:0]            ram_type_wr,
    output logic                  ram_wr_ins,
    input  logic                  ram_wr_idle,
    output logic [ADDR_WIDTH-1:0] ram_addr_rd,
    input  logic [63:0]           ram_data_rd
);
    state_e                state, state_nx;
    logic                  wr_q, err_q;
    logic [1:0]            type_q;
    logic [ADDR_WIDTH-1:0] addr_q, base;
    logic [63:0]           wdata_q, lo_q, hi_q, load_data;
    logic [2:0]            idx_q;
    logic                  accept, req_err, split, last;

    assign accept  = req_valid && state == IDLE;
    assign req_err = req_type == SZ_ILL || int'(req_addr) + int'(size_bytes(req_type)) > ADDR_DEPTH;
    // Misaligned stores degrade to one byte write per cycle pair, idx_q walks the bytes
    assign split   = wr_q && ((type_q == SZ_WORD && addr_q[1:0] != 2'b00) || (type_q == SZ_DWORD && addr_q[2:0] != 3'b000));
    assign last    = !split || idx_q == (type_q == SZ_DWORD ? 3'd7 : 3'd3);
    assign base    = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (req_valid) state_nx = req_err ? RESP : req_wr ? WR_ISSUE : RD0;
            RD0:      state_nx = (type_q == SZ_DWORD && addr_q[1:0] != 2'b00) ? RD1 : RESP;
            RD1:      state_nx = RESP;
            WR_ISSUE: if (ram_wr_idle) state_nx = WR_WAIT;
            WR_WAIT:  state_nx = last ? RESP : WR_ISSUE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            type_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            idx_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wr_q    <= req_wr;
                err_q   <= req_err;
                type_q  <= req_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                idx_q   <= '0;
            end
            if (state == RD0) lo_q <= ram_data_rd;
            if (state == RD1) hi_q <= ram_data_rd;
            if (state == WR_WAIT && !last) idx_q <= idx_q + 3'd1;
        end
    end

    mem_byte_align u_align (
        .lo    (lo_q),
        .hi    (hi_q),
        .shift (addr_q[1:0]),
        .size  (type_q),
        .data  (load_data)
    );

    assign req_ready   = state == IDLE;
    assign rsp_valid   = state == RESP;
    assign rsp_err     = rsp_valid && err_q;
    assign rsp_rdata   = (rsp_valid && !wr_q && !err_q) ? load_data : '0;
    assign ram_wr_ins  = state == WR_ISSUE && ram_wr_idle;
    assign ram_addr_wr = state == WR_ISSUE ? addr_q + ADDR_WIDTH'(idx_q) : '0;
    assign ram_data_wr = state != WR_ISSUE ? '0 : split ? {56'd0, wdata_q[{idx_q, 3'b000} +: 8]} : wdata_q & size_mask(type_q);
    assign ram_type_wr = (state == WR_ISSUE && !split) ? type_q : SZ_BYTE;
    assign ram_addr_rd = state == RD0 ? base : state == RD1 ? base + ADDR_WIDTH'(8) : '0;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_DEPTH, default 2048, byte count of the attached data RAM.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(ADDR_DEPTH), byte address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, a request is present.
REQ-006 SHALL have port req_ready, output, 1, the unit accepts a request this cycle.
REQ-007 SHALL have port req_wr, input, 1, 1=store, 0=load.
REQ-008 SHALL have port req_type, input, 2, access size: 0=byte, 1=word (4B), 2=doubleword (8B), 3=illegal.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH, byte address; any alignment allowed.
REQ-010 SHALL have port req_wdata, input, 64, store data, little-endian, LSB-justified.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 64, load data, zero-extended; 0 for stores and errors.
REQ-013 SHALL have port rsp_err, output, 1, request rejected; qualified by rsp_valid.
REQ-014 SHALL have port ram_addr_wr / ram_data_wr / ram_type_wr, output, ADDR_WIDTH/64/2, RAM write address, data and size.
REQ-015 SHALL have port ram_wr_ins, output, 1, RAM write strobe.
REQ-016 SHALL have port ram_wr_idle, input, 1, RAM write path idle.
REQ-017 SHALL have port ram_addr_rd, output, ADDR_WIDTH, RAM read address, always a multiple of 4.
REQ-018 SHALL have port ram_data_rd, input, 64, combinational RAM read window, bytes ram_addr_rd..ram_addr_rd+7.

Function
REQ-019 SHALL implement states IDLE, RD0, RD1, WR_ISSUE, WR_WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL accept a request on the rising edge where req_valid and req_ready are both 1, registering req_wr, req_type, req_addr and req_wdata.
REQ-021 SHALL flag an error when req_type==3 or req_addr+size>ADDR_DEPTH; go directly to RESP with rsp_err=1 and perform no RAM access.
REQ-022 SHALL treat a store as aligned when it is a byte, a word with addr[1:0]==0, or a dword with addr[2:0]==0, and issue exactly one RAM write of req_type.
REQ-023 SHALL split any other store into 4 (word) or 8 (dword) byte writes at ascending addresses, byte k = wdata[8k+7:8k] written to addr+k.
REQ-024 SHALL, in WR_ISSUE, hold until ram_wr_idle==1, then pulse ram_wr_ins for one cycle and move to WR_WAIT.
REQ-025 SHALL stay in WR_WAIT for exactly one cycle, then go to WR_ISSUE if bytes remain, otherwise to RESP.
REQ-026 SHALL give these store latencies from the acceptance edge: aligned store rsp_valid in cycle 3; split word store in cycle 9; split dword store in cycle 17, provided ram_wr_idle never stalls.
REQ-027 SHALL, for loads, drive ram_addr_rd = addr & ~3 in RD0 and capture ram_data_rd at the end of RD0.
REQ-028 SHALL enter RD1 only for a dword load with addr[1:0]!=0; RD1 drives (addr & ~3)+8 and captures the upper window.
REQ-029 SHALL form load data from the 16-byte concatenation {upper, lower} shifted right by 8*addr[1:0], masked to size and zero-extended.
REQ-030 SHALL give these load latencies: rsp_valid in cycle 2 after acceptance (RD0 path) or cycle 3 (RD0+RD1 path).
REQ-031 SHALL make RESP last one cycle (rsp_valid=1), then return to IDLE; responses are never backpressured.
REQ-032 SHALL make ram_wr_ins 0 in every state except WR_ISSUE with ram_wr_idle==1.

Reset
REQ-033 SHALL, on rst_n low, go asynchronously to IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_wr_ins=0, ram_addr_wr=0, ram_data_wr=0, ram_type_wr=0, ram_addr_rd=0.
REQ-034 SHALL, on reset mid-operation, abandon the request with no response; bytes already written remain in the RAM.

Structure
REQ-035 SHALL take the size encodings (0/1/2), ADDR_DEPTH default and the state enum from shared package mem_pkg.
REQ-036 SHALL place the 16-byte shift/mask/zero-extend logic in combinational sub-module mem_byte_align.

Verification
REQ-037 SHALL test an aligned dword store: addr 0x010, data 0x1122334455667788 -> one ram_wr_ins, type 2, rsp_valid in cycle 3, rsp_err=0.
REQ-038 SHALL test a misaligned word store: addr 0x005, data 0xAABBCCDD -> four byte writes to 0x005..0x008 carrying DD, CC, BB, AA, rsp_valid in cycle 9.
REQ-039 SHALL test a misaligned dword load: RAM bytes 0x003..0x00A = 01..08 -> RD1 visited, rsp_rdata=0x0807060504030201 in cycle 3.
REQ-040 SHALL test errors: word at 0x7FE, and req_type=3 -> rsp_err=1, no ram_wr_ins, rsp_valid in cycle 1.
REQ-041 SHALL test a stall: ram_wr_idle held 0 for 3 cycles during a byte store -> ram_wr_ins is delayed until idle and pulses exactly once.
REQ-042 SHALL test reset during a split dword store after 3 bytes -> outputs take their reset values immediately, only 3 bytes are written, and no rsp_valid is produced.
